// File: rtl/mem_pkg.sv
// Shared access codes and FSM state type for the data memory responder.
package mem_pkg;

  localparam logic [2:0] ACC_B  = 3'd0;
  localparam logic [2:0] ACC_H  = 3'd1;
  localparam logic [2:0] ACC_W  = 3'd2;
  localparam logic [2:0] ACC_BU = 3'd4;
  localparam logic [2:0] ACC_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane selection, load extension, store strobes and access-code checks.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic        store,
  input  logic [2:0]  access,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic        err,
  output logic [3:0]  wstrb,
  output logic [31:0] wlane,
  output logic [31:0] rdata
);

  logic [31:0] shifted;
  logic        bad_code;
  logic        misal;

  always_comb begin
    shifted  = rword >> {addr_lo, 3'b000};
    wlane    = wdata << {addr_lo, 3'b000};
    bad_code = 1'b0;
    misal    = 1'b0;
    wstrb    = 4'b0000;
    rdata    = 32'b0;
    unique case (access)
      ACC_B: begin
        wstrb = 4'b0001 << addr_lo;
        rdata = {{24{shifted[7]}}, shifted[7:0]};
      end
      ACC_H: begin
        misal = addr_lo[0];
        wstrb = 4'b0011 << addr_lo;
        rdata = {{16{shifted[15]}}, shifted[15:0]};
      end
      ACC_W: begin
        misal = |addr_lo;
        wstrb = 4'b1111;
        rdata = rword;
      end
      ACC_BU: begin
        bad_code = store;
        rdata    = {24'b0, shifted[7:0]};
      end
      ACC_HU: begin
        bad_code = store;
        misal    = addr_lo[0];
        rdata    = {16'b0, shifted[15:0]};
      end
      default: bad_code = 1'b1;
    endcase
    err = bad_code | misal;
    // strobes only for good stores, data only for good loads
    if (err || !store) wstrb = 4'b0000;
    if (err || store)  rdata = 32'b0;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Single-port data memory behind a valid/ready request/response handshake
// with a fixed number of wait states per access.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_access,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          store_q, store_d;
  logic [2:0]    acc_q, acc_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          rdy_q, rdy_d;
  logic          vld_q, vld_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   rword, wlane, lrdata;
  logic [3:0]    wstrb;
  logic          lerr;
  logic          accept, enter_resp;
  logic          unused_hi;

  assign unused_hi  = ^req_addr[31:AW+2];
  assign rword      = mem[addr_q[AW+1:2]];
  assign accept     = (state_q == IDLE) && req_valid && rdy_q;
  assign enter_resp = (state_q == WAIT) && (cnt_q == 4'd0);

  mem_lane_align u_align (
    .store   (store_q),
    .access  (acc_q),
    .addr_lo (addr_q[1:0]),
    .wdata   (wdata_q),
    .rword   (rword),
    .err     (lerr),
    .wstrb   (wstrb),
    .wlane   (wlane),
    .rdata   (lrdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      store_q <= 1'b0;
      acc_q   <= 3'd0;
      addr_q  <= '0;
      wdata_q <= 32'b0;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
      rdata_q <= 32'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      store_q <= store_d;
      acc_q   <= acc_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Zero wait states still spend one cycle in WAIT so latency is W+1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    store_d = store_q;
    acc_d   = acc_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: if (accept) begin
        state_d = WAIT;
        cnt_d   = 4'(WAIT_CYCLES);
        store_d = req_store;
        acc_d   = req_access;
        addr_d  = req_addr[AW+1:0];
        wdata_d = req_wdata;
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdy_d   = (state_d == IDLE);
    vld_d   = (state_d == RESP);
    rdata_d = rdata_q;
    err_d   = err_q;
    if (enter_resp) begin
      rdata_d = lrdata;
      err_d   = lerr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && enter_resp) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[addr_q[AW+1:2]][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  assign req_ready  = rdy_q;
  assign resp_valid = vld_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed plus randomized checks of two responders (2 and 0 wait states)
// against a byte-array memory model.
module tb_data_mem_responder;

  localparam int NBYTES = 4096;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid, req_ready, req_store;
  logic [1:0]  resp_valid, resp_ready, resp_err;
  logic [2:0]  req_access [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [31:0] resp_rdata [2];

  logic [7:0]  mm [2][NBYTES];
  int          checks, errors;

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_store(req_store[0]), .req_access(req_access[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_store(req_store[1]), .req_access(req_access[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model(input int d, input bit st, input logic [2:0] acc,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output bit er);
    int sz, a;
    logic [31:0] v;
    sz = (acc[1:0] == 2'd0) ? 1 : (acc[1:0] == 2'd1) ? 2 : 4;
    a  = int'(addr % NBYTES);
    er = st ? (acc > 3'd2) : (acc == 3'd3 || acc > 3'd5);
    if (!er && (a % sz) != 0) er = 1'b1;
    rd = 32'b0;
    if (er) return;
    if (st) begin
      for (int i = 0; i < sz; i++) mm[d][a+i] = 8'(wd >> (8*i));
    end else begin
      v = 32'b0;
      for (int i = 0; i < sz; i++) v = v | (32'(mm[d][a+i]) << (8*i));
      if (acc < 3'd4 && sz == 1 && v[7])  v = v | 32'hFFFF_FF00;
      if (acc < 3'd4 && sz == 2 && v[15]) v = v | 32'hFFFF_0000;
      rd = v;
    end
  endtask

  task automatic xact(input int d, input bit st, input logic [2:0] acc,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input int hold,
                      output logic [31:0] rd, output bit er);
    logic [31:0] erd;
    bit eer;
    int n;
    model(d, st, acc, addr, wd, erd, eer);
    @(negedge clk);
    req_valid[d] = 1'b1; req_store[d] = st; req_access[d] = acc;
    req_addr[d] = addr; req_wdata[d] = wd;
    n = 0;
    while (!req_ready[d] && n < 20) begin @(negedge clk); n++; end
    chk("req_ready_idle", 32'(req_ready[d]), 32'd1);
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    n = 0;
    while (!resp_valid[d] && n < 40) begin @(posedge clk); #1; n++; end
    chk("latency", 32'(n), (d == 0) ? 32'd3 : 32'd1);
    rd = resp_rdata[d];
    er = resp_err[d];
    chk("rdata", rd, erd);
    chk("err", 32'(er), 32'(eer));
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(resp_valid[d]), 32'd1);
      chk("hold_rdata", resp_rdata[d], rd);
      chk("hold_err", 32'(resp_err[d]), 32'(er));
      chk("hold_req_ready", 32'(req_ready[d]), 32'd0);
    end
    resp_ready[d] = 1'b1;
    @(posedge clk); #1;
    resp_ready[d] = 1'b0;
    chk("valid_drop", 32'(resp_valid[d]), 32'd0);
    chk("ready_back", 32'(req_ready[d]), 32'd1);
  endtask

  initial begin
    logic [31:0] rd, a, w;
    bit er;
    logic [2:0] acc;
    checks = 0; errors = 0;
    rst = 1'b1;
    req_valid = '0; req_store = '0; resp_ready = '0;
    for (int d = 0; d < 2; d++) begin
      req_access[d] = 3'd0; req_addr[d] = 32'd0; req_wdata[d] = 32'd0;
    end

    // reset state
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_req_ready", 32'(req_ready[d]), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid[d]), 32'd0);
      chk("rst_rdata", resp_rdata[d], 32'd0);
      chk("rst_err", 32'(resp_err[d]), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", 32'(req_ready[0]), 32'd1);

    // fill a 128-byte window of both memories so every model byte is known
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 32; i++)
        xact(d, 1'b1, 3'd2, 32'(4*i), $urandom, 0, rd, er);

    // word store/load and extension
    xact(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, rd, er);
    chk("sw_rdata", rd, 32'd0);
    xact(0, 1'b0, 3'd2, 32'h10, 32'd0, 0, rd, er);
    chk("lw", rd, 32'hDEADBEEF);
    chk("lw_err", 32'(er), 32'd0);
    xact(0, 1'b0, 3'd0, 32'h13, 32'd0, 0, rd, er);
    chk("lb", rd, 32'hFFFFFFDE);
    xact(0, 1'b0, 3'd4, 32'h13, 32'd0, 0, rd, er);
    chk("lbu", rd, 32'h000000DE);
    xact(0, 1'b0, 3'd1, 32'h12, 32'd0, 0, rd, er);
    chk("lh", rd, 32'hFFFFDEAD);
    xact(0, 1'b0, 3'd5, 32'h10, 32'd0, 0, rd, er);
    chk("lhu", rd, 32'h0000BEEF);

    // byte store merges into the word
    xact(0, 1'b1, 3'd0, 32'h11, 32'h55, 0, rd, er);
    xact(0, 1'b0, 3'd2, 32'h10, 32'd0, 0, rd, er);
    chk("sb_merge", rd, 32'hDEAD55EF);

    // misaligned accesses
    xact(0, 1'b0, 3'd2, 32'h12, 32'd0, 0, rd, er);
    chk("lw_mis_err", 32'(er), 32'd1);
    chk("lw_mis_rdata", rd, 32'd0);
    xact(0, 1'b1, 3'd1, 32'h11, 32'hFFFF, 0, rd, er);
    chk("sh_mis_err", 32'(er), 32'd1);
    xact(0, 1'b0, 3'd2, 32'h10, 32'd0, 0, rd, er);
    chk("sh_mis_nowrite", rd, 32'hDEAD55EF);

    // back-pressure on the response
    xact(0, 1'b0, 3'd2, 32'h10, 32'd0, 5, rd, er);
    chk("hold_lw", rd, 32'hDEAD55EF);

    // zero wait states
    xact(1, 1'b1, 3'd2, 32'h40, 32'h01234567, 0, rd, er);
    xact(1, 1'b0, 3'd1, 32'h42, 32'd0, 2, rd, er);
    chk("w0_lh", rd, 32'h00000123);

    // reset in the middle of a store's wait states
    xact(0, 1'b1, 3'd2, 32'h20, 32'hAAAAAAAA, 0, rd, er);
    xact(0, 1'b0, 3'd2, 32'h10, 32'd0, 0, rd, er);
    @(negedge clk);
    req_valid[0] = 1'b1; req_store[0] = 1'b1; req_access[0] = 3'd2;
    req_addr[0] = 32'h20; req_wdata[0] = 32'h12345678;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_req_ready", 32'(req_ready[0]), 32'd0);
    chk("mid_rst_valid", 32'(resp_valid[0]), 32'd0);
    chk("mid_rst_rdata", resp_rdata[0], 32'd0);
    chk("mid_rst_err", 32'(resp_err[0]), 32'd0);
    @(posedge clk); #1;
    chk("mid_rst_valid2", 32'(resp_valid[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_ready_back", 32'(req_ready[0]), 32'd1);
    xact(0, 1'b0, 3'd2, 32'h20, 32'd0, 0, rd, er);
    chk("aborted_sw", rd, 32'hAAAAAAAA);

    // randomized traffic; high address bits exercise wrap-around
    for (int i = 0; i < 60; i++) begin
      a   = ($urandom << 12) | 32'($urandom_range(0, 127));
      acc = 3'($urandom_range(0, 7));
      w   = $urandom;
      xact((i % 4 == 3) ? 1 : 0, 1'($urandom), acc, a, w,
           $urandom_range(0, 2), rd, er);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
